approx_mult_rr_sched: RTL and testbench
=======================================

// Module: approx_mult_rr_sched
// PURPOSE
//  Shares one approximate 8x8 multiplier (approx_8x8) between NREQ requesters in the CNN datapath.
//  - Round-robin arbitration: at most one operand pair accepted per cycle.
//  - Operands pass through a 2-stage registered pipeline around the multiplier.
//  - Each product returns tagged with the requester ID; the response port supports backpressure.
//  - Also counts completed multiplies for the performance monitor.
// PARAMETERS
//  NREQ   4   number of requesters, 2..16
//  IDW    2   ID width, = clog2(NREQ); derived via the package function, not user-set
//  CNTW   32  width of the completed-operation counter
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         synchronous reset, active-high
//  req_valid  in   NREQ      bit i: requester i presents an operand pair
//  req_a      in   8*NREQ    requester i operand A at [8*i+:8], unsigned
//  req_b      in   8*NREQ    requester i operand B at [8*i+:8], unsigned
//  req_ready  out  NREQ      one-hot or zero; bit i = pair i accepted this cycle
//  rsp_valid  out  1         rsp_p/rsp_id valid
//  rsp_ready  in   1         consumer accepts the response
//  rsp_id     out  IDW       index of the requester that issued this product
//  rsp_p      out  16        approx_8x8 product of the accepted pair
//  op_count   out  CNTW      number of responses consumed (rsp_valid & rsp_ready), wraps
// BEHAVIOUR
//  Reset (sync): s0_v=0, s1_v=0, rsp_valid=0, rr_ptr=0, op_count=0.
//    - rsp_id and rsp_p are reset to 0.
//    - req_ready is 0 during a cycle in which rst=1.
//    - In-flight operations are dropped and are not counted.
//  Enable: adv = !s1_v | rsp_ready. The whole pipeline advances only when adv=1; otherwise it holds.
//  Arbitration (combinational, only when adv=1):
//    - g = first i with req_valid[i], searching from rr_ptr upward, modulo NREQ.
//    - req_ready[g]=1; all other bits 0.
//    - No valid requests -> req_ready=0 and a bubble enters s0.
//    - req_ready depends on req_valid. A requester must not withdraw valid or change operands until it sees ready.
//  rr_ptr <= (g+1) mod NREQ on each accepted transfer; it is unchanged otherwise.
//    - g=NREQ-1 wraps the pointer to 0.
//  Stage 0, on adv: s0_v <= |req_ready; s0_a/s0_b/s0_id <= the granted operands and ID.
//  Multiplier: approx_8x8 is combinational between s0 and s1, with A=s0_a, B=s0_b.
//  Stage 1, on adv: s1_v <= s0_v; s1_p <= the multiplier output; s1_id <= s0_id.
//    - rsp_valid=s1_v, rsp_p=s1_p, rsp_id=s1_id.
//  Latency: accepted in cycle t -> rsp_valid in cycle t+2 if no stall. Throughput is 1 per cycle.
//  Bubbles are not collapsed during a stall; the pipeline holds as a unit.
//  Stall: while rsp_valid=1 and rsp_ready=0, rsp_p and rsp_id stay stable and req_ready is all zero.
//  Same-cycle response consume and new grant is legal: adv=1 when rsp_ready=1.
//  op_count increments by 1 when rsp_valid & rsp_ready; it wraps from 2^CNTW-1 to 0.
//  Products are exactly what approx_8x8 produces. No rounding, truncation or sign handling is done here.
// STRUCTURE
//  Package approx_mult_pkg:
//    - constants OPW=8 and PW=16;
//    - function clog2 (for IDW);
//    - typedef of the pipeline stage record {v, a, b, id, p}.
//  Sub-module rr_arbiter #(N):
//    - inputs req, ptr, en; outputs grant (one-hot) and idx;
//    - purely combinational.
//  Instance of approx_8x8; the multiplier variant is selected inside that wrapper, not here.
// TESTING
//  Golden model: a bit-exact C/SV model of the selected approx_8x8 variant.
//  1 Single requester: req 1 with A=0x00, B=0x5A, then A=0x01, B=0x01 back-to-back
//    -> rsp_id=1 at t+2 and t+3; P=golden(0,0x5A) then golden(1,1); op_count=2.
//  2 All NREQ=4 valid continuously with rsp_ready=1 from reset
//    -> grant order 0,1,2,3,0,... and one response per cycle in the same ID order.
//  3 Backpressure: rsp_ready=0 for 5 cycles with 2 ops in flight
//    -> rsp_p/rsp_id stable, req_ready=0, op_count unchanged;
//    -> after release, both responses arrive in order on consecutive cycles.
//  4 Pointer wrap/fairness: only reqs 3 and 0 valid
//    -> grants alternate 3,0,3,0; requesters 1 and 2 are never granted.
//  5 Reset mid-operation: rst=1 for 1 cycle with s0 and s1 full
//    -> next cycle rsp_valid=0, op_count=0; the first grant after reset goes to requester 0.
//  6 Exhaustive sweep: all 65536 A,B pairs through requester 2
//    -> every rsp_p equals golden(A,B) and op_count=65536.

Source files
------------

// File: rtl/approx_mult_rr_sched_pkg.sv
// Shared constants, ID-width helper and pipeline stage record for the
// shared approximate multiplier scheduler.
package approx_mult_pkg;

  localparam int OPW   = 8;
  localparam int PW    = 16;
  localparam int IDMAX = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // id is sized for the largest supported requester count (16)
  typedef struct packed {
    logic             v;
    logic [OPW-1:0]   a;
    logic [OPW-1:0]   b;
    logic [IDMAX-1:0] id;
    logic [PW-1:0]    p;
  } stage_t;

endpackage

// File: rtl/approx_mult_rr_sched_if.sv
// Request/response bundle between the requesters, the scheduler and the
// product consumer.
interface approx_mult_rr_sched_if
  import approx_mult_pkg::*;
#(
  parameter int NREQ = 4
);
  localparam int IDW = clog2(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [OPW*NREQ-1:0] req_a;
  logic [OPW*NREQ-1:0] req_b;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [PW-1:0]       rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );

endinterface

// File: rtl/approx_8x8.sv
// Approximate unsigned 8x8 multiplier: partial-product bits whose column
// weight is below DROP_COLS are discarded.
module approx_8x8
  import approx_mult_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [PW-1:0]  p
);
  localparam int unsigned DROP_COLS = 4;

  logic [PW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < OPW; i++) begin
      for (int unsigned j = 0; j < OPW; j++) begin
        if (i + j >= DROP_COLS) begin
          acc = acc + (PW'(a[i] & b[j]) << (i + j));
        end
      end
    end
  end

  assign p = acc;

endmodule

// File: rtl/approx_mult_rr_sched_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import approx_mult_pkg::*;
#(
  parameter int N = 4
)(
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  input  logic                  en,
  output logic [N-1:0]          grant,
  output logic [clog2(N)-1:0]   idx
);
  localparam int IDW = clog2(N);

  logic           found;
  logic [IDW-1:0] j_idx;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j_idx = '0;
    if (en) begin
      for (int unsigned k = 0; k < N; k++) begin
        j_idx = IDW'((int'(ptr) + k) % N);
        if (!found && req[j_idx]) begin
          found        = 1'b1;
          grant[j_idx] = 1'b1;
          idx          = j_idx;
        end
      end
    end
  end

endmodule

// File: rtl/approx_mult_rr_sched.sv
// Round-robin scheduler sharing one approximate 8x8 multiplier between
// NREQ requesters through a 2-stage pipeline with response backpressure.
module approx_mult_rr_sched
  import approx_mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CNTW = 32
)(
  input  logic                 clk,
  input  logic                 rst,
  approx_mult_rr_sched_if.slave bus,
  output logic [CNTW-1:0]      op_count
);
  localparam int IDW = clog2(NREQ);

  stage_t          s0_q, s0_d;
  stage_t          s1_q, s1_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  g_idx;
  logic [NREQ-1:0] grant;
  logic            adv;
  logic            fire;
  logic [PW-1:0]   mult_p;
  logic [CNTW-1:0] op_count_q;
  logic            unused_bits;

  // The whole pipeline moves as one unit; bubbles are not squeezed out.
  assign adv  = !s1_q.v || bus.rsp_ready;
  assign fire = s1_q.v && bus.rsp_ready;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .en    (adv && !rst),
    .grant (grant),
    .idx   (g_idx)
  );

  approx_8x8 u_mul (
    .a (s0_q.a),
    .b (s0_q.b),
    .p (mult_p)
  );

  always_comb begin
    s0_d    = '0;
    s0_d.v  = |grant;
    s0_d.a  = bus.req_a[OPW*int'(g_idx) +: OPW];
    s0_d.b  = bus.req_b[OPW*int'(g_idx) +: OPW];
    s0_d.id = IDMAX'(g_idx);

    s1_d   = s0_q;
    s1_d.p = mult_p;

    rr_ptr_d = rr_ptr_q;
    if (|grant) begin
      rr_ptr_d = (g_idx == IDW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q       <= '0;
      s1_q       <= '0;
      rr_ptr_q   <= '0;
      op_count_q <= '0;
    end else begin
      if (adv) begin
        s0_q     <= s0_d;
        s1_q     <= s1_d;
        rr_ptr_q <= rr_ptr_d;
      end
      if (fire) begin
        op_count_q <= op_count_q + CNTW'(1);
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = s1_q.v;
  assign bus.rsp_id    = s1_q.id[IDW-1:0];
  assign bus.rsp_p     = s1_q.p;
  assign op_count      = op_count_q;

  assign unused_bits = ^{s0_q.p, s1_q.a, s1_q.b, s1_q.id};

endmodule

// File: tb/tb_approx_mult_rr_sched.sv
// Directed bench for approx_mult_rr_sched with a response scoreboard and a
// bit-exact reference of the approximate multiplier.
module tb_approx_mult_rr_sched;

  localparam int NREQ = 4;

  logic        clk;
  logic        rst;
  logic [31:0] op_count;

  approx_mult_rr_sched_if #(.NREQ(NREQ)) bus ();

  approx_mult_rr_sched #(.NREQ(NREQ), .CNTW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] p;
  } exp_t;

  exp_t        sb[$];
  int          nchk, npass, nfail;
  logic        mv0, mv1;
  int          ptr;
  logic [31:0] cnt;
  int          last_g;
  bit          oneshot, after_rst;
  logic [3:0]  obs_ready;
  logic [3:0]  seen12;
  logic [31:0] c0;

  // Exact product minus every partial-product bit in columns 0..3.
  function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b);
    int unsigned exact;
    int unsigned err;
    exact = int'(a) * int'(b);
    err   = 0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i <= k; i++)
        err += int'(a[i] & b[k-i]) << k;
    return 16'(exact - err);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] eg;
    int         g;
    logic       adv;
    @(negedge clk);
    obs_ready = bus.req_ready;
    g = -1;
    if (rst) begin
      check("rst_req_ready", bus.req_ready, 0);
      mv0 = 0; mv1 = 0; ptr = 0; cnt = 0;
      sb.delete();
      after_rst = 1;
    end else begin
      if (after_rst) begin
        check("rst_rsp_p", bus.rsp_p, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        after_rst = 0;
      end
      check("op_count", op_count, cnt);
      check("rsp_valid", bus.rsp_valid, mv1);
      if (mv1) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          check("rsp_id", bus.rsp_id, sb[0].id);
          check("rsp_p", bus.rsp_p, sb[0].p);
        end
      end
      adv = !mv1 || bus.rsp_ready;
      eg  = '0;
      if (adv)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && bus.req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
      if (g >= 0) eg[g] = 1'b1;
      check("req_ready", bus.req_ready, eg);
      if (mv1 && bus.rsp_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        cnt++;
      end
      if (adv) begin
        mv1 = mv0;
        mv0 = (g >= 0);
        if (g >= 0) begin
          sb.push_back('{id: g, p: golden(bus.req_a[8*g +: 8], bus.req_b[8*g +: 8])});
          ptr = (g + 1) % NREQ;
        end
      end
    end
    last_g = g;
    @(posedge clk);
    #1;
    if (last_g >= 0) begin
      if (oneshot) bus.req_valid[last_g] = 1'b0;
      else begin
        bus.req_a[8*last_g +: 8] = 8'($urandom);
        bus.req_b[8*last_g +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic send(input int idx, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[8*idx +: 8] = a;
    bus.req_b[8*idx +: 8] = b;
    bus.req_valid[idx]    = 1'b1;
    for (int w = 0; w < 20 && bus.req_valid[idx]; w++) tick();
    check("send_granted", bus.req_valid[idx], 0);
  endtask

  task automatic settle();
    oneshot = 1;
    for (int w = 0; w < 40 && bus.req_valid != 0; w++) tick();
    check("settle", bus.req_valid, 0);
  endtask

  task automatic drain();
    for (int w = 0; w < 50 && (sb.size() > 0 || mv0 || mv1); w++) tick();
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    nchk = 0; npass = 0; nfail = 0;
    mv0 = 0; mv1 = 0; ptr = 0; cnt = 0; last_g = -1;
    oneshot = 1; after_rst = 0; seen12 = '0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // 1: single requester, back-to-back
    send(1, 8'h00, 8'h5A);
    send(1, 8'h01, 8'h01);
    repeat (3) tick();
    check("t1_op_count", op_count, 2);

    // 2: all requesters continuously valid from reset
    pulse_reset();
    oneshot = 0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[8*i +: 8] = 8'($urandom);
      bus.req_b[8*i +: 8] = 8'($urandom);
    end
    bus.req_valid = 4'b1111;
    repeat (12) tick();
    settle();
    drain();

    // 3: backpressure with two operations in flight
    oneshot = 1;
    bus.req_a[7:0]  = 8'hC3; bus.req_b[7:0]  = 8'h7E;
    bus.req_a[15:8] = 8'hFF; bus.req_b[15:8] = 8'hFF;
    bus.req_valid   = 4'b0011;
    tick();
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_a[23:16] = 8'h9D; bus.req_b[23:16] = 8'h42;
    bus.req_valid[2] = 1'b1;
    c0 = cnt;
    repeat (5) tick();
    check("t3_count_held", op_count, c0);
    bus.rsp_ready = 1'b1;
    settle();
    drain();

    // 4: only requesters 3 and 0 compete
    oneshot = 0;
    bus.req_valid = 4'b1001;
    seen12 = '0;
    repeat (8) begin
      tick();
      seen12 = seen12 | (obs_ready & 4'b0110);
    end
    check("t4_no_grant_1_2", seen12, 0);
    settle();
    drain();

    // 5: reset while both stages hold work
    oneshot = 0;
    bus.req_valid = 4'b1111;
    repeat (4) tick();
    pulse_reset();
    tick();
    check("t5_first_grant", obs_ready, 4'b0001);
    check("t5_op_count", op_count, 0);
    settle();
    drain();

    // 6: exhaustive operand sweep through requester 2
    pulse_reset();
    oneshot = 1;
    for (int v = 0; v < 65536; v++) send(2, v[15:8], v[7:0]);
    drain();
    check("t6_op_count", op_count, 65536);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
